// File: rtl/sgb_pkg.sv
// +----------------------------------------------------------------------------+
// | sgb_pkg: constants and FSM encoding shared by the SGB packet TX and ICD2 RX |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sgb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RST_LO  = 3'd1,
    ST_RST_HI  = 3'd2,
    ST_BIT_LO  = 3'd3,
    ST_BIT_HI  = 3'd4,
    ST_STOP_LO = 3'd5,
    ST_STOP_HI = 3'd6
  } sgb_state_t;

  // Line values are {P15,P14}; a low line is the active pulse.
  localparam logic [1:0] JOY_IDLE = 2'b11;
  localparam logic [1:0] JOY_RST  = 2'b00;
  localparam logic [1:0] JOY_BIT0 = 2'b10;
  localparam logic [1:0] JOY_BIT1 = 2'b01;

  localparam int SGB_PKT_BYTES = 16;

  function automatic logic [1:0] joy_bit_enc(input logic b);
    return b ? JOY_BIT1 : JOY_BIT0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sgb_pkt_tx.sv
// +----------------------------------------------------------------------------+
// | sgb_pkt_tx: serialises a 16-byte SGB command packet onto the P14/P15 lines |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sgb_pkt_tx
  import sgb_pkg::*;
#(
  parameter int PULSE_TICKS = 5,
  parameter int IDLE_TICKS  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       wr,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [1:0] joy_p54
);

  localparam int RST_TICKS = 3 * PULSE_TICKS;
  localparam int MAX_TICKS = (RST_TICKS > IDLE_TICKS) ? RST_TICKS : IDLE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;

  localparam logic [CW-1:0] RST_LAST   = CW'(RST_TICKS - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_TICKS - 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_TICKS - 1);

  sgb_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic [6:0]    idx;
  logic [6:0]    idx_nxt;
  logic          cur_bit;
  logic          nxt_bit;
  logic [7:0]    pkt_buf [SGB_PKT_BYTES];

  // Writes are locked out while a packet is in flight so the stream stays coherent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SGB_PKT_BYTES; i++) begin
        pkt_buf[i] <= '0;
      end
    end else if (wr && !busy) begin
      pkt_buf[waddr] <= wdata;
    end
  end

  assign idx_nxt = idx + 7'd1;
  assign cur_bit = pkt_buf[idx[6:3]][idx[2:0]];
  assign nxt_bit = pkt_buf[idx_nxt[6:3]][idx_nxt[2:0]];

  always_comb begin
    limit = '0;
    case (state)
      ST_RST_LO:                         limit = RST_LAST;
      ST_BIT_LO, ST_STOP_LO:             limit = PULSE_LAST;
      ST_RST_HI, ST_BIT_HI, ST_STOP_HI:  limit = IDLE_LAST;
      default:                           limit = '0;
    endcase
  end

  // Line value is registered and updated on the same edge as the state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx     <= '0;
      joy_p54 <= JOY_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        joy_p54 <= JOY_IDLE;
        if (start) begin
          state   <= ST_RST_LO;
          cnt     <= '0;
          idx     <= '0;
          joy_p54 <= JOY_RST;
          busy    <= 1'b1;
        end
      end else if (ce) begin
        if (cnt != limit) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= '0;
          case (state)
            ST_RST_LO: begin
              state   <= ST_RST_HI;
              joy_p54 <= JOY_IDLE;
            end
            ST_RST_HI: begin
              state   <= ST_BIT_LO;
              joy_p54 <= joy_bit_enc(cur_bit);
            end
            ST_BIT_LO: begin
              state   <= ST_BIT_HI;
              joy_p54 <= JOY_IDLE;
            end
            ST_BIT_HI: begin
              if (idx == 7'd127) begin
                state   <= ST_STOP_LO;
                joy_p54 <= JOY_BIT0;
              end else begin
                idx     <= idx_nxt;
                state   <= ST_BIT_LO;
                joy_p54 <= joy_bit_enc(nxt_bit);
              end
            end
            ST_STOP_LO: begin
              state   <= ST_STOP_HI;
              joy_p54 <= JOY_IDLE;
            end
            ST_STOP_HI: begin
              state   <= ST_IDLE;
              joy_p54 <= JOY_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
            default: begin
              state   <= ST_IDLE;
              joy_p54 <= JOY_IDLE;
              busy    <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sgb_pkt_tx.sv
// +----------------------------------------------------------------------------+
// | tb_sgb_pkt_tx: randomized self-checking bench with a per-tick line model   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sgb_pkt_tx;

  localparam int P = 5;
  localparam int I = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce;
  logic       wr = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [1:0] joy;

  sgb_pkt_tx #(.PULSE_TICKS(P), .IDLE_TICKS(I)) dut (
    .clk(clk), .reset(reset), .ce(ce), .wr(wr), .waddr(waddr), .wdata(wdata),
    .start(start), .busy(busy), .done(done), .joy_p54(joy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         ce_mode = 0;  // 0 every clock, 1 every 3rd, 2 random, 3 held low
  logic [1:0] rec [$];
  logic [1:0] expq [$];
  logic [1:0] ref_q [$];
  logic [7:0] mbuf [16];
  logic [7:0] dec_bytes [16];
  int         dec_nbits;
  logic       dec_stop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int div = 0;
    ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ce_mode)
        0: ce = 1'b1;
        1: begin div = (div + 1) % 3; ce = (div == 0); end
        2: ce = 1'($urandom_range(0, 1));
        default: ce = 1'b0;
      endcase
    end
  end

  // Line value is captured once per ce tick while a packet is in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && busy && ce) rec.push_back(joy);
      if (done) done_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d);
    wr = 1'b1; waddr = 4'(a); wdata = d;
    tick();
    wr = 1'b0;
    mbuf[a] = d;
  endtask

  // Expected packet as a per-tick line sequence built from the protocol rules.
  task automatic build_expected();
    expq.delete();
    repeat (3 * P) expq.push_back(2'b00);
    repeat (I) expq.push_back(2'b11);
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 8; k++) begin
        repeat (P) expq.push_back(mbuf[b][k] ? 2'b01 : 2'b10);
        repeat (I) expq.push_back(2'b11);
      end
    end
    repeat (P) expq.push_back(2'b10);
    repeat (I) expq.push_back(2'b11);
  endtask

  // Receiver-style decode: each falling edge into a non-idle value is one symbol.
  task automatic decode_rec();
    logic [1:0] prev;
    logic       bits [256];
    prev = 2'b11;
    dec_nbits = 0;
    for (int i = 0; i < 256; i++) bits[i] = 1'b0;
    foreach (rec[i]) begin
      if (rec[i] != prev && rec[i] != 2'b11) begin
        if (rec[i] == 2'b00) dec_nbits = 0;
        else begin
          if (dec_nbits < 256) bits[dec_nbits] = (rec[i] == 2'b01);
          dec_nbits++;
        end
      end
      prev = rec[i];
    end
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 8; k++) dec_bytes[b][k] = bits[b * 8 + k];
    dec_stop = bits[128];
  endtask

  task automatic do_start();
    rec.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_joy", 32'(joy), 32'h0);
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 30000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic verify_packet(input string tag);
    int bad = -1;
    build_expected();
    check({tag, "_len"}, 32'(rec.size()), 32'(expq.size()));
    for (int i = 0; i < rec.size() && i < expq.size(); i++)
      if (bad < 0 && rec[i] !== expq[i]) bad = i;
    check({tag, "_first_bad_tick"}, 32'(bad), 32'hFFFF_FFFF);
    decode_rec();
    check({tag, "_nbits"}, 32'(dec_nbits), 32'd129);
    check({tag, "_stop"}, 32'(dec_stop), 32'd0);
    for (int b = 0; b < 16; b++)
      check($sformatf("%s_byte%0d", tag, b), 32'(dec_bytes[b]), 32'(mbuf[b]));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_joy", 32'(joy), 32'h3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // single set bit: exact 2610-tick sequence
    ce_mode = 0;
    wr_byte(0, 8'h01);
    do_start();
    wait_done("t1");
    verify_packet("t1");

    // counting bytes with random ce, plus a ce-held-low stall
    for (int i = 0; i < 16; i++) wr_byte(i, 8'(i));
    ce_mode = 2;
    do_start();
    repeat (300) tick();
    begin
      logic [1:0] j0;
      int         s0;
      ce_mode = 3;
      repeat (2) tick();
      j0 = joy; s0 = rec.size();
      repeat (40) tick();
      check("hold_joy", 32'(joy), 32'(j0));
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_ticks", 32'(rec.size()), 32'(s0));
      ce_mode = 2;
    end
    wait_done("t2");
    verify_packet("t2");

    // start/wr hammering while busy must not disturb the packet
    ce_mode = 0;
    do_start();
    for (int i = 0; i < 200; i++) begin
      start = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      waddr = 4'h0;
      wdata = 8'hAA;
      tick();
    end
    start = 1'b0; wr = 1'b0;
    wait_done("t3");
    repeat (20) tick();
    check("t3_single_done", 32'(done_cnt), 32'd3);
    verify_packet("t3");
    ref_q = rec;

    // same buffer at ce every 3rd clock: identical tick sequence
    ce_mode = 1;
    do_start();
    wait_done("t5");
    verify_packet("t5");
    begin
      int diff = 0;
      if (rec.size() != ref_q.size()) diff = 1;
      else foreach (rec[i]) if (rec[i] !== ref_q[i]) diff = 1;
      check("t5_same_as_fast", 32'(diff), 32'd0);
    end

    // reset during bit 60
    ce_mode = 0;
    for (int i = 0; i < 16; i++) wr_byte(i, 8'($urandom));
    do_start();
    begin
      int n = 0;
      while (rec.size() < 3 * P + I + 60 * (P + I) + 2 && n < 10000) begin
        @(negedge clk);
        n++;
      end
      check("t4_reached_bit60", 32'(n < 10000), 32'd1);
    end
    #2 reset = 1'b1;
    #1;
    check("t4_joy_async", 32'(joy), 32'h3);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mbuf[i] = 8'h00;
    tick();
    do_start();
    wait_done("t4z");
    verify_packet("t4z");

    // write to byte 15 in the same cycle as start
    wr_byte(3, 8'($urandom));
    rec.delete();
    wr = 1'b1; waddr = 4'hF; wdata = 8'h80; start = 1'b1;
    mbuf[15] = 8'h80;
    tick();
    wr = 1'b0; start = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    wait_done("t6");
    verify_packet("t6");
    check("t6_bit127", 32'(dec_bytes[15][7]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
